// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
//
// Shared constants for the multicycle MIPS-style control unit:
//   - state_t   : FSM state encodings (also visible on the State debug port)
//   - OP_*      : primary opcode values (instruction[31:26])
//   - ALUOP_*   : ALU operation class handed to the ALU control block
//   - PCSRC_*   : PC source mux select codes
//   - SRCB_*    : ALU B-operand mux select codes
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

   // FSM states. Codes 12-15 are unused and recover to FETCH.
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALUOp codes
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // PCSource codes
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALUSrcB codes
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Moore-style main control FSM for a multicycle MIPS subset
// (lw, sw, R-type, beq, j, addi). All outputs are decoded purely from the
// registered state; Opcode only steers the next-state choice.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous active-high reset, forces FETCH
//   Opcode     in   instruction[31:26] from the instruction register
//   PCWrite    out  unconditional PC load
//   BranchType out  conditional PC load (qualified externally by Branch)
//   PCSource   out  PC mux select (00 ALU, 01 ALUOut, 10 jump target)
//   IorD       out  memory address select (0 PC, 1 ALUOut)
//   MemRead    out  memory read strobe
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register load
//   RegDst     out  write-register select (0 rt, 1 rd)
//   MemtoReg   out  writeback select (0 ALUOut, 1 MDR)
//   RegWrite   out  register file write enable
//   ALUSrcA    out  ALU A select (0 PC, 1 register A)
//   ALUSrcB    out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   ALUOp      out  ALU operation class (00 add, 01 sub, 10 funct)
//   State      out  current state code, for debug observation
// ---------------------------------------------------------------------------
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   output logic       PCWrite,
   output logic       BranchType,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [3:0] State
);

   state_t state;
   state_t next_state;

   // State register. Reset is asynchronous so the FETCH control word
   // appears on the outputs as soon as reset rises, even mid-instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= next_state;
      end
   end

   assign State = state;

   // Next-state logic and Moore output decode.
   always_comb begin
      next_state = S_FETCH;
      PCWrite    = 1'b0;
      BranchType = 1'b0;
      PCSource   = PCSRC_ALU;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_B;
      ALUOp      = ALUOP_ADD;

      case (state)
         S_FETCH: begin
            // Read instruction at PC and compute PC+4 in the same cycle.
            MemRead    = 1'b1;
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ALUOp      = ALUOP_ADD;
            PCSource   = PCSRC_ALU;
            next_state = S_DECODE;
         end

         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut.
            ALUSrcB = SRCB_IMMSH2;
            ALUOp   = ALUOP_ADD;
            case (Opcode)
               OP_RTYPE:     next_state = S_EXEC;
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_BEQ:       next_state = S_BRANCH;
               OP_J:         next_state = S_JUMP;
               OP_ADDI:      next_state = S_ADDIEX;
               default:      next_state = S_FETCH;
            endcase
         end

         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            // IR holds the opcode, so it is still lw or sw here.
            if (Opcode == OP_SW) begin
               next_state = S_MEMWR;
            end else begin
               next_state = S_MEMRD;
            end
         end

         S_MEMRD: begin
            MemRead    = 1'b1;
            IorD       = 1'b1;
            next_state = S_MEMWB;
         end

         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            RegDst     = 1'b0;
            next_state = S_FETCH;
         end

         S_MEMWR: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            next_state = S_FETCH;
         end

         S_EXEC: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_B;
            ALUOp      = ALUOP_FUNCT;
            next_state = S_ALUWB;
         end

         S_ALUWB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            MemtoReg   = 1'b0;
            next_state = S_FETCH;
         end

         S_BRANCH: begin
            // Compare via subtract; PC loads the precomputed target only
            // when the external zero/Branch condition qualifies BranchType.
            BranchType = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_B;
            ALUOp      = ALUOP_SUB;
            PCSource   = PCSRC_ALUOUT;
            next_state = S_FETCH;
         end

         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = PCSRC_JUMP;
            next_state = S_FETCH;
         end

         S_ADDIEX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_IMM;
            ALUOp      = ALUOP_ADD;
            next_state = S_ADDIWB;
         end

         S_ADDIWB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            next_state = S_FETCH;
         end

         // Unused codes: all outputs stay at their zero defaults and the
         // machine recovers to FETCH on the next edge.
         default: begin
            next_state = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed and random instruction streams for multicycle_control. The
// reference model describes each instruction as a list of state codes
// visited, a cycle count, and a per-state control word taken from the
// instruction-step tables.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

   logic       clk;
   logic       reset;
   logic [5:0] Opcode;
   logic       PCWrite, BranchType, IorD, MemRead, MemWrite, IRWrite;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] PCSource, ALUSrcB, ALUOp;
   logic [3:0] State;

   int total = 0;
   int bad   = 0;

   typedef int path_t[$];

   multicycle_control dut (
      .clk        (clk),
      .reset      (reset),
      .Opcode     (Opcode),
      .PCWrite    (PCWrite),
      .BranchType (BranchType),
      .PCSource   (PCSource),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .State      (State)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed control word, fixed field order used by exp_ctrl too.
   logic [15:0] ctrl_obs;
   assign ctrl_obs = {PCWrite, BranchType, PCSource, IorD, MemRead, MemWrite,
                      IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                      ALUSrcB, ALUOp};

   // Expected control word for each state, listed field by field.
   function automatic logic [15:0] exp_ctrl(input int s);
      logic pcw, brt, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
      logic [1:0] pcs, srcb, aop;
      pcw = 0; brt = 0; iord = 0; mrd = 0; mwr = 0; irw = 0;
      rdst = 0; m2r = 0; rw = 0; srca = 0; pcs = 0; srcb = 0; aop = 0;
      case (s)
         0:  begin mrd = 1; irw = 1; pcw = 1; srcb = 2'b01; end
         1:  begin srcb = 2'b11; end
         2:  begin srca = 1; srcb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin srca = 1; aop = 2'b10; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin brt = 1; srca = 1; aop = 2'b01; pcs = 2'b01; end
         9:  begin pcw = 1; pcs = 2'b10; end
         10: begin srca = 1; srcb = 2'b10; end
         11: begin rw = 1; end
         default: ;
      endcase
      return {pcw, brt, pcs, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop};
   endfunction

   // States visited by one instruction, starting from its FETCH.
   function automatic path_t exp_path(input logic [5:0] op);
      path_t p;
      case (op)
         6'b100011: p = '{0, 1, 2, 3, 4};
         6'b101011: p = '{0, 1, 2, 5};
         6'b000000: p = '{0, 1, 6, 7};
         6'b001000: p = '{0, 1, 10, 11};
         6'b000100: p = '{0, 1, 8};
         6'b000010: p = '{0, 1, 9};
         default:   p = '{0, 1};
      endcase
      return p;
   endfunction

   // Cycles per instruction, kept as an independent table.
   function automatic int exp_cycles(input logic [5:0] op);
      case (op)
         6'b100011: return 5;
         6'b101011: return 4;
         6'b000000: return 4;
         6'b001000: return 4;
         6'b000100: return 3;
         6'b000010: return 3;
         default:   return 2;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_exclusive(input string tag);
      chk({tag, "_pcw_brt"}, 16'(PCWrite & BranchType), 16'd0);
      chk({tag, "_rd_wr"},   16'(MemRead & MemWrite),   16'd0);
   endtask

   // Run one instruction from its FETCH until the DUT returns to FETCH,
   // checking every cycle. Called and returns on a negative edge.
   task automatic run_instr(input logic [5:0] op, input string tag);
      path_t p;
      int    c;
      int    es;
      p = exp_path(op);
      Opcode = op;
      c = 0;
      while (c < 16) begin
         es = (c < p.size()) ? p[c] : 0;
         chk({tag, "_state"}, 16'(State), 16'(es));
         chk({tag, "_ctrl"},  ctrl_obs,   exp_ctrl(es));
         chk_exclusive(tag);
         @(negedge clk);
         c++;
         if (State == 4'd0) break;
      end
      chk({tag, "_cycles"}, 16'(c), 16'(exp_cycles(op)));
   endtask

   logic [5:0] legal_ops [6];

   initial begin
      legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};

      // Reset
      reset  = 1'b0;
      Opcode = 6'd0;
      #2 reset = 1'b1;
      #1;
      chk("reset_state", 16'(State), 16'd0);
      chk("reset_ctrl",  ctrl_obs,   exp_ctrl(0));
      @(negedge clk);
      @(negedge clk);
      chk("reset_hold", 16'(State), 16'd0);
      reset = 1'b0;

      // Directed instructions
      run_instr(6'b100011, "lw");
      run_instr(6'b101011, "sw");
      run_instr(6'b000000, "rtype");
      run_instr(6'b001000, "addi");
      run_instr(6'b000100, "beq");
      run_instr(6'b000010, "j");
      run_instr(6'b111111, "illegal");

      // Reset pulse while in MEMRD
      Opcode = 6'b100011;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_memrd", 16'(State), 16'd3);
      reset = 1'b1;
      #1;
      chk("mid_rst_state", 16'(State), 16'd0);
      chk("mid_rst_memread", 16'(MemRead), 16'd1);
      chk("mid_rst_irwrite", 16'(IRWrite), 16'd1);
      chk("mid_rst_pcwrite", 16'(PCWrite), 16'd1);
      chk("mid_rst_ctrl", ctrl_obs, exp_ctrl(0));
      @(negedge clk);
      chk("mid_rst_hold", 16'(State), 16'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_decode", 16'(State), 16'd1);
      Opcode = 6'b111111;
      @(negedge clk);
      chk("post_rst_refetch", 16'(State), 16'd0);

      // Random instruction stream
      for (int i = 0; i < 1000; i++) begin
         logic [5:0] op;
         if ($urandom_range(0, 6) == 6) op = 6'($urandom_range(0, 63));
         else op = legal_ops[$urandom_range(0, 5)];
         run_instr(op, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
